// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: FSM encoding, register map
// and the code-to-source mapping.
package irq_pkg;

    localparam int MAX_SRC = 7;
    localparam int GIE_BIT = 7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_INJECT = 2'd1;
    localparam logic [1:0] ST_INSERV = 2'd2;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;

    typedef logic [2:0] irq_code_t;

    // Code 0 means "no interrupt", so source k is presented as k+1.
    function automatic irq_code_t idx_to_code(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit request synchroniser followed by a rising-edge detector.
// edge_o is high for one cycle per synchronised 0->1 transition.
module irq_sync_edge
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: latches edge requests, injects one code
// into the core for a single cycle and holds off until return-from-interrupt.
//
// state      | meaning
// IDLE       | waiting for an eligible request and cpu_ready
// INJECT     | int_code nonzero for exactly this cycle
// IN_SERVICE | handler running; waits for ret_int, no nesting
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC        = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_req_i,
    input  logic            cpu_ready_i,
    input  logic            ret_int_i,
    output logic [2:0]      int_code_o,
    output logic            int_active_o,
    input  logic            cfg_we_i,
    input  logic [1:0]      cfg_addr_i,
    input  logic [7:0]      cfg_wdata_i,
    output logic [7:0]      cfg_rdata_o
);

    logic [1:0]      state_q, state_d;
    irq_code_t       code_q, code_d;
    irq_code_t       svc_q, svc_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] en_q, en_d;
    logic            gie_q, gie_d;

    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] win_onehot;
    logic [2:0]      win_idx;
    logic            win_found;
    logic            inject;
    logic [NSRC-1:0] inj_clr;
    logic [NSRC-1:0] sw_clr;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk   (clk),
            .reset (reset),
            .req_i (irq_req_i[g]),
            .edge_o(edge_det[g])
        );
    end

    assign eligible = gie_q ? (pend_q & en_q) : '0;

    // Scan from the top down so the lowest set index is the one left standing.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = 3'd0;
        win_onehot = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found     = 1'b1;
                win_idx       = 3'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign inject  = (state_q == ST_IDLE) && win_found && cpu_ready_i;
    assign inj_clr = inject ? win_onehot : '0;
    assign sw_clr  = (cfg_we_i && cfg_addr_i == REG_PEND) ? cfg_wdata_i[NSRC-1:0] : '0;

    // A fresh edge wins over any clear landing on the same bit.
    assign pend_d = (pend_q & ~inj_clr & ~sw_clr) | edge_det;

    always_comb begin
        gie_d = gie_q;
        en_d  = en_q;
        if (cfg_we_i && cfg_addr_i == REG_CTRL) begin
            gie_d = cfg_wdata_i[GIE_BIT];
            en_d  = cfg_wdata_i[NSRC-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = 3'd0;
        svc_d   = svc_q;
        case (state_q)
            ST_IDLE: begin
                if (inject) begin
                    state_d = ST_INJECT;
                    code_d  = idx_to_code(win_idx);
                end
            end
            ST_INJECT: begin
                state_d = ST_INSERV;
                svc_d   = code_q;
            end
            ST_INSERV: begin
                if (ret_int_i) begin
                    state_d = ST_IDLE;
                    svc_d   = 3'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                svc_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            code_q  <= 3'd0;
            svc_q   <= 3'd0;
            pend_q  <= '0;
            en_q    <= '0;
            gie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            svc_q   <= svc_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            gie_q   <= gie_d;
        end
    end

    assign int_code_o   = code_q;
    assign int_active_o = (state_q == ST_INSERV);

    always_comb begin
        cfg_rdata_o = 8'h00;
        case (cfg_addr_i)
            REG_CTRL: begin
                cfg_rdata_o[GIE_BIT] = gie_q;
                for (int i = 0; i < NSRC; i++) cfg_rdata_o[i] = en_q[i];
            end
            REG_PEND: begin
                for (int i = 0; i < NSRC; i++) cfg_rdata_o[i] = pend_q[i];
            end
            REG_STAT: begin
                cfg_rdata_o[2:0] = svc_q;
                cfg_rdata_o[4:3] = state_q;
            end
            default: cfg_rdata_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a cycle-level reference model predicts every injection
// into a scoreboard queue that a separate monitor drains as int_code pulses appear.
module tb_irq_ctrl;

    localparam int NSRC = 7;
    localparam int S    = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_req;
    logic            cpu_ready, ret_int, cfg_we;
    logic [1:0]      cfg_addr;
    logic [7:0]      cfg_wdata, cfg_rdata;
    logic [2:0]      int_code;
    logic            int_active;

    always #5 clk = ~clk;

    irq_ctrl #(.NSRC(NSRC), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_req_i   (irq_req),
        .cpu_ready_i (cpu_ready),
        .ret_int_i   (ret_int),
        .int_code_o  (int_code),
        .int_active_o(int_active),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rdata_o (cfg_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    typedef struct {
        int cyc;
        int code;
    } inj_t;
    inj_t exp_q[$];
    inj_t mon_e;

    // Reference model: pin history, pending set, CTRL, and a phase number
    // (0 idle, 1 injecting, 2 in service) matching the STAT encoding.
    logic [NSRC-1:0] hist[$];
    logic [NSRC-1:0] m_pend = '0;
    logic [NSRC-1:0] m_en   = '0;
    logic            m_gie  = 1'b0;
    int              m_state = 0;
    int              m_code  = 0;
    int              m_svc   = 0;

    function automatic int lowest(input logic [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] a);
        logic [7:0] r;
        r = 8'h00;
        case (a)
            2'd0: r = {m_gie, m_en};
            2'd1: r = {1'b0, m_pend};
            2'd2: r = {3'b000, 2'(m_state), 3'(m_svc)};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Advance the model across the coming clock edge using the driven inputs.
    task automatic model_step();
        logic [NSRC-1:0] edge_v, elig, clr, sw;
        int sel, last, n_state, n_code, n_svc;
        if (reset) begin
            m_pend = '0; m_en = '0; m_gie = 1'b0;
            m_state = 0; m_code = 0; m_svc = 0;
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back('0);
            return;
        end
        hist.push_back(irq_req);
        last   = hist.size() - 1;
        edge_v = hist[last-S] & ~hist[last-S-1];
        void'(hist.pop_front());
        elig = m_gie ? (m_pend & m_en) : '0;
        sel  = lowest(elig);
        clr  = '0;
        sw   = '0;
        n_state = m_state; n_code = 0; n_svc = m_svc;
        if (m_state == 0) begin
            if (sel >= 0 && cpu_ready) begin
                clr[sel] = 1'b1;
                n_state  = 1;
                n_code   = sel + 1;
                exp_q.push_back('{cyc + 1, sel + 1});
            end
        end else if (m_state == 1) begin
            n_state = 2;
            n_svc   = m_code;
        end else if (ret_int) begin
            n_state = 0;
            n_svc   = 0;
        end
        if (cfg_we && cfg_addr == 2'd1) sw = cfg_wdata[NSRC-1:0];
        m_pend = (m_pend & ~clr & ~sw) | edge_v;
        if (cfg_we && cfg_addr == 2'd0) begin
            m_gie = cfg_wdata[7];
            m_en  = cfg_wdata[NSRC-1:0];
        end
        m_state = n_state; m_code = n_code; m_svc = n_svc;
    endtask

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (int_active !== (m_state == 2)) begin
                errors++;
                $display("FAIL int_active cyc %0d: got %0b expected %0b", cyc, int_active, m_state == 2);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_injection cyc %0d: got none expected code %0d at cyc %0d",
                         cyc, exp_q[0].code, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (int_code !== 3'd0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_injection cyc %0d: got code %0d expected none", cyc, int_code);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.code != int_code || mon_e.cyc != cyc) begin
                        errors++;
                        $display("FAIL injection cyc %0d: got code %0d expected code %0d at cyc %0d",
                                 cyc, int_code, mon_e.code, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic ret();
        ret_int = 1'b1;
        tick();
        ret_int = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic rd_chk(input logic [1:0] a);
        logic [7:0] e;
        cfg_addr = a;
        #1;
        e = model_read(a);
        checks++;
        if (cfg_rdata !== e) begin
            errors++;
            $display("FAIL cfg_read addr %0d cyc %0d: got %02h expected %02h", a, cyc, cfg_rdata, e);
        end
    endtask

    task automatic rd_const(input string name, input logic [1:0] a, input int exp);
        cfg_addr = a;
        #1;
        chk(name, int'(cfg_rdata), exp);
    endtask

    task automatic wait_inj(output int n, output int code);
        n = 0;
        while (int_code == 3'd0 && n < 20) begin
            tick();
            n++;
        end
        code = int'(int_code);
    endtask

    int n, c;

    initial begin
        reset = 1'b1; irq_req = '0; cpu_ready = 1'b1; ret_int = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
        @(negedge clk);
        #1;
        idle(3);
        reset = 1'b0;
        started = 1'b1;

        chk("reset_code", int'(int_code), 0);
        chk("reset_active", int'(int_active), 0);
        rd_const("reset_ctrl", 2'd0, 0);
        rd_const("reset_pend", 2'd1, 0);
        tick();
        rd_const("reset_stat", 2'd2, 0);
        rd_const("reset_addr3", 2'd3, 0);

        // Basic injection
        wr(2'd0, 8'h84);
        irq_req = 7'b0000100;
        wait_inj(n, c);
        irq_req = '0;
        chk("basic_latency", n, S + 2);
        chk("basic_code", c, 3);
        tick();
        chk("basic_code_one_cycle", int'(int_code), 0);
        rd_const("basic_stat", 2'd2, 8'h13);
        rd_const("basic_pend", 2'd1, 0);
        ret();

        // Priority: source 1 before source 5, second one right after IDLE
        wr(2'd0, 8'hFF);
        irq_req = 7'b0100010;
        wait_inj(n, c);
        irq_req = '0;
        chk("prio_first", c, 2);
        tick();
        ret();
        wait_inj(n, c);
        chk("prio_gap", n, 1);
        chk("prio_second", c, 6);
        tick();
        ret();

        // Masking by gie
        wr(2'd0, 8'h01);
        irq_req = 7'b0000001;
        tick();
        irq_req = '0;
        idle(6);
        chk("mask_code", int'(int_code), 0);
        rd_const("mask_pend", 2'd1, 8'h01);
        wr(2'd0, 8'h81);
        wait_inj(n, c);
        chk("unmask_latency", n, 1);
        chk("unmask_code", c, 1);
        tick();
        ret();

        // No nesting
        wr(2'd0, 8'hFF);
        irq_req = 7'b0000010;
        wait_inj(n, c);
        irq_req = '0;
        chk("nest_first", c, 2);
        tick();
        irq_req = 7'b0000001;
        tick();
        irq_req = '0;
        idle(6);
        rd_const("nest_pend", 2'd1, 8'h01);
        chk("nest_active", int'(int_active), 1);
        ret();
        wait_inj(n, c);
        chk("nest_after_ret", c, 1);
        tick();
        ret();

        // Stall on cpu_ready
        cpu_ready = 1'b0;
        irq_req = 7'b0000100;
        tick();
        irq_req = '0;
        idle(8);
        chk("stall_code", int'(int_code), 0);
        rd_const("stall_pend", 2'd1, 8'h04);
        cpu_ready = 1'b1;
        wait_inj(n, c);
        chk("stall_release", n, 1);
        chk("stall_code_after", c, 3);
        tick();
        ret();

        // Set beats clear on source 3
        wr(2'd0, 8'h00);
        irq_req = 7'b0001000;
        tick();
        irq_req = '0;
        idle(5);
        rd_const("race_pre", 2'd1, 8'h08);
        irq_req = 7'b0001000;
        idle(S);
        wr(2'd1, 8'h08);
        irq_req = '0;
        rd_const("race_set_wins", 2'd1, 8'h08);
        wr(2'd1, 8'h08);
        rd_const("race_clear", 2'd1, 8'h00);
        wr(2'd3, 8'hFF);
        rd_chk(2'd0);

        // Reset during INJECT
        wr(2'd0, 8'hFF);
        irq_req = 7'b1010000;
        wait_inj(n, c);
        irq_req = '0;
        chk("rst_inject_code", c, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_code", int'(int_code), 0);
        rd_const("rst_stat", 2'd2, 0);
        rd_const("rst_pend", 2'd1, 0);
        rd_const("rst_ctrl", 2'd0, 0);
        idle(6);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 400 == 0);
            for (int b = 0; b < NSRC; b++)
                if ($urandom % 8 == 0) irq_req[b] = ~irq_req[b];
            cpu_ready = ($urandom % 4 != 0);
            ret_int   = (m_state == 2 && $urandom % 3 == 0) || ($urandom % 50 == 0);
            rd_chk(2'($urandom % 4));
            cfg_we    = ($urandom % 10 == 0);
            cfg_addr  = 2'($urandom % 4);
            cfg_wdata = 8'($urandom);
            if (cfg_addr == 2'd0 && $urandom % 4 != 0) cfg_wdata[7] = 1'b1;
            tick();
        end
        reset = 1'b0; cfg_we = 1'b0; ret_int = 1'b0; irq_req = '0; cpu_ready = 1'b1;
        idle(6);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
